dac_spi_driver: RTL and testbench
=================================

DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DAC_RES_WIDTH, 12, sample width; legal range 1..12.
- SCLK_DIV, 2, sys_clk cycles per SCLK half-period; legal value >= 1.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- sys_clk_i  in  1  system clock; the only clock.
- sys_rst_i  in  1  reset, synchronous, active-high.
- ds_start_i  in  1  transfer request, sampled on each sys_clk edge.
- ds_en_1_i  in  1  channel 1 enable.
- ds_en_2_i  in  1  channel 2 enable.
- ds_data_1_i  in  DAC_RES_WIDTH  channel 1 sample from the sine generator.
- ds_data_2_i  in  DAC_RES_WIDTH  channel 2 sample from the sine generator.
- ds_busy_o  out  1  transfer in progress.
- ds_done_o  out  1  one-cycle pulse when a transfer completes.
- ds_sclk_o  out  1  SPI clock, idles low (mode 0).
- ds_mosi_o  out  1  SPI data, MSB first.
- ds_cs_n_o  out  1  chip select, active low.
- ds_ldac_n_o  out  1  DAC load strobe, active low.

Function
REQ-003 FSM states SHALL be: IDLE, LOAD, SHIFT, GAP, LDAC, DONE.
REQ-004 In IDLE, ds_start_i=1 SHALL cause a move to LOAD.
REQ-005 In every state other than IDLE, ds_start_i SHALL be ignored; no queuing.
REQ-006 ds_busy_o SHALL be 1 in every state except IDLE.
REQ-007 LOAD SHALL register both data inputs and both enables; later input changes SHALL NOT affect the transfer in progress.
REQ-008 LOAD SHALL select the first enabled channel (ch1 before ch2) and go to SHIFT.
REQ-009 If no channel is enabled, LOAD SHALL go directly to DONE, with no CS, SCLK or LDAC activity.
REQ-010 Frame SHALL be 16 bits, MSB first: bit15=0, bit14=0, bit13=channel (0=ch1, 1=ch2), bit12=1, bits11..0=sample left-aligned with zero fill below.
REQ-011 On entering SHIFT, ds_cs_n_o SHALL go 0 and ds_mosi_o SHALL present bit15 on the same cycle.
REQ-012 SCLK SHALL rise after SCLK_DIV cycles and fall after a further SCLK_DIV cycles.
REQ-013 ds_mosi_o SHALL change only on SCLK falling edges, advancing to the next bit.
REQ-014 Each frame SHALL have exactly 16 rising edges and 16 falling edges; CS low time = 32*SCLK_DIV cycles.
REQ-015 After the 16th falling edge, ds_cs_n_o SHALL go 1, ds_mosi_o 0, and the FSM SHALL enter GAP.
REQ-016 GAP SHALL last SCLK_DIV cycles with CS high.
REQ-017 After GAP, the FSM SHALL go to SHIFT if channel 2 is enabled and not yet sent, otherwise to LDAC.
REQ-018 LDAC SHALL hold ds_ldac_n_o=0 for exactly SCLK_DIV cycles, then go to DONE.
REQ-019 DONE SHALL assert ds_done_o for one cycle, then return to IDLE; ds_busy_o SHALL be 0 on the following cycle.
REQ-020 A ds_start_i asserted in the DONE cycle SHALL be ignored; a start is accepted only in IDLE.
REQ-021 Total cycles from LOAD entry to DONE inclusive SHALL be 1 + n*33*SCLK_DIV + SCLK_DIV + 1, where n = number of enabled channels (1 or 2); for n=0 it SHALL be 2.
REQ-022 Divider counter SHALL be ceil(log2(SCLK_DIV+1)) bits and bit counter 5 bits; both SHALL wrap only under FSM control.

Reset
REQ-023 With sys_rst_i=1 at a clock edge, the FSM SHALL enter IDLE and outputs SHALL be: busy=0, done=0, sclk=0, mosi=0, cs_n=1, ldac_n=1.
REQ-024 Reset during SHIFT, GAP or LDAC SHALL abort immediately; no further SCLK edges and no LDAC pulse SHALL occur.
REQ-025 Reset SHALL take priority over ds_start_i in the same cycle.

Verification
REQ-026 Both channels, SCLK_DIV=2, data_1=12'hABC, data_2=12'h123, start pulse -> frames 16'h1ABC then 16'h3123; 32 SCLK rises; two CS-low windows of 64 cycles each; one 2-cycle LDAC low; done 136 cycles after LOAD entry.
REQ-027 Only ch2 enabled, data_2=12'h800 -> single frame 16'h3800, then LDAC, then done; no ch1 frame.
REQ-028 Both enables 0, start -> busy for 2 cycles, one done pulse, cs_n/sclk/ldac_n never toggle.
REQ-029 Start held high throughout, plus data changed mid-frame -> exactly one transfer per IDLE visit; transmitted bits match values latched at LOAD.
REQ-030 Reset asserted at the 5th SCLK rise of frame 1 -> next cycle cs_n=1, sclk=0, busy=0; no LDAC pulse; a new start afterwards completes normally.
REQ-031 DAC_RES_WIDTH=8, SCLK_DIV=1, data_1=8'hFF, ch1 only -> frame 16'h1FF0; CS low for 32 cycles.

Source files
------------

// File: rtl/dac_spi_driver.sv
// Two-channel SPI driver for a serial DAC: shifts one 16-bit frame per enabled channel,
// then strobes LDAC so both channel outputs update together.
module dac_spi_driver #(
   parameter int unsigned DAC_RES_WIDTH = 12,
   parameter int unsigned SCLK_DIV      = 2
) (
   input  logic                     sys_clk_i,
   input  logic                     sys_rst_i,
   input  logic                     ds_start_i,
   input  logic                     ds_en_1_i,
   input  logic                     ds_en_2_i,
   input  logic [DAC_RES_WIDTH-1:0] ds_data_1_i,
   input  logic [DAC_RES_WIDTH-1:0] ds_data_2_i,
   output logic                     ds_busy_o,
   output logic                     ds_done_o,
   output logic                     ds_sclk_o,
   output logic                     ds_mosi_o,
   output logic                     ds_cs_n_o,
   output logic                     ds_ldac_n_o
);

   localparam int unsigned DivW = $clog2(SCLK_DIV + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StGap,
      StLdac,
      StDone
   } state_e;

   state_e                   state_q, state_d;
   logic [DivW-1:0]          div_q, div_d;
   logic [4:0]               bit_q, bit_d;
   logic                     sclk_q, sclk_d;
   logic [15:0]              shift_q, shift_d;
   logic                     ch_q, ch_d;
   logic                     en2_q, en2_d;
   logic [DAC_RES_WIDTH-1:0] data2_q, data2_d;
   logic                     div_last;

   // Sample is left-aligned into the 12-bit field with zero fill below.
   function automatic logic [15:0] make_frame(input logic ch,
                                              input logic [DAC_RES_WIDTH-1:0] sample);
      logic [11:0] aligned;
      aligned = 12'(sample) << (12 - DAC_RES_WIDTH);
      return {2'b00, ch, 1'b1, aligned};
   endfunction

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         div_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         shift_q <= '0;
         ch_q    <= 1'b0;
         en2_q   <= 1'b0;
         data2_q <= '0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         shift_q <= shift_d;
         ch_q    <= ch_d;
         en2_q   <= en2_d;
         data2_q <= data2_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sclk_d   = sclk_q;
      shift_d  = shift_q;
      ch_d     = ch_q;
      en2_d    = en2_q;
      data2_d  = data2_q;
      div_last = (div_q == DivLast);
      unique case (state_q)
         StIdle: begin
            if (ds_start_i) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Channel 1 is captured straight into the shift register; channel 2 waits.
            en2_d   = ds_en_2_i;
            data2_d = ds_data_2_i;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            if (ds_en_1_i) begin
               ch_d    = 1'b0;
               shift_d = make_frame(1'b0, ds_data_1_i);
               state_d = StShift;
            end else if (ds_en_2_i) begin
               ch_d    = 1'b1;
               shift_d = make_frame(1'b1, ds_data_2_i);
               state_d = StShift;
            end else begin
               shift_d = '0;
               state_d = StDone;
            end
         end
         StShift: begin
            if (div_last) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  if (bit_q == 5'd15) begin
                     bit_d   = '0;
                     shift_d = '0;
                     state_d = StGap;
                  end else begin
                     bit_d   = bit_q + 5'd1;
                     shift_d = {shift_q[14:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StGap: begin
            if (div_last) begin
               div_d = '0;
               if (!ch_q && en2_q) begin
                  ch_d    = 1'b1;
                  shift_d = make_frame(1'b1, data2_q);
                  state_d = StShift;
               end else begin
                  state_d = StLdac;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StLdac: begin
            if (div_last) begin
               div_d   = '0;
               state_d = StDone;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      ds_busy_o   = (state_q != StIdle);
      ds_done_o   = (state_q == StDone);
      ds_cs_n_o   = (state_q != StShift);
      ds_ldac_n_o = (state_q != StLdac);
      ds_sclk_o   = sclk_q;
      ds_mosi_o   = (state_q == StShift) ? shift_q[15] : 1'b0;
   end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: stimulus pushes expected frames and latencies into queues,
// bus monitors reconstruct frames from SCLK/MOSI/CS and compare.
module tb_dac_spi_driver;

   localparam int unsigned Div = 2;

   logic        clk = 1'b0;
   logic        rst, start, en1, en2;
   logic [11:0] d1, d2;
   logic        busy, done, sclk, mosi, cs_n, ldac_n;

   logic        start8, en1_8;
   logic [7:0]  d1_8, d2_8;
   logic        busy8, done8, sclk8, mosi8, cs_n8, ldac_n8;

   always #5 clk = ~clk;

   dac_spi_driver #(.DAC_RES_WIDTH(12), .SCLK_DIV(Div)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .ds_start_i(start), .ds_en_1_i(en1), .ds_en_2_i(en2),
      .ds_data_1_i(d1), .ds_data_2_i(d2), .ds_busy_o(busy), .ds_done_o(done),
      .ds_sclk_o(sclk), .ds_mosi_o(mosi), .ds_cs_n_o(cs_n), .ds_ldac_n_o(ldac_n)
   );

   dac_spi_driver #(.DAC_RES_WIDTH(8), .SCLK_DIV(1)) dut8 (
      .sys_clk_i(clk), .sys_rst_i(rst), .ds_start_i(start8), .ds_en_1_i(en1_8),
      .ds_en_2_i(1'b0), .ds_data_1_i(d1_8), .ds_data_2_i(d2_8), .ds_busy_o(busy8),
      .ds_done_o(done8), .ds_sclk_o(sclk8), .ds_mosi_o(mosi8), .ds_cs_n_o(cs_n8),
      .ds_ldac_n_o(ldac_n8)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] exp_frames[$];
   int          exp_lat[$];
   logic [15:0] exp8[$];
   int          lat8[$];

   bit          mon_en = 1'b0;
   bit          abort_exp = 1'b0;
   logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_busy = 1'b0, p_done = 1'b0;
   logic [15:0] cap = '0;
   int          rise_cnt = 0, cs_start = 0, ldac_len = 0, load_cyc = 0;
   int          rises_total = 0, cs_falls = 0, ldac_pulses = 0, dones = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (p_done) check("busy_after_done", busy, 0);
         if (busy && !p_busy) load_cyc = cyc;
         if (!cs_n && p_cs) begin
            cs_start = cyc;
            cap      = '0;
            rise_cnt = 0;
            cs_falls++;
         end
         if (sclk && !p_sclk) begin
            cap = {cap[14:0], mosi};
            rise_cnt++;
            rises_total++;
            check("cs_low_at_rise", cs_n, 0);
         end
         if (cs_n && !p_cs) begin
            if (abort_exp) begin
               check("abort_rises", rise_cnt, 5);
               abort_exp = 1'b0;
            end else if (exp_frames.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got %0h expected none", cap);
            end else begin
               check("frame", cap, exp_frames.pop_front());
               check("frame_rises", rise_cnt, 16);
               check("cs_low_len", cyc - cs_start, 32 * Div);
            end
         end
         if (!ldac_n) ldac_len++;
         if (ldac_n && !p_ldac) begin
            ldac_pulses++;
            check("ldac_len", ldac_len, Div);
            ldac_len = 0;
         end
         if (done) begin
            dones++;
            if (exp_lat.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
               check("latency", cyc - load_cyc + 1, exp_lat.pop_front());
            end
         end
         p_sclk = sclk;
         p_cs   = cs_n;
         p_ldac = ldac_n;
         p_busy = busy;
         p_done = done;
      end
   end

   logic        p_sclk8 = 1'b0, p_cs8 = 1'b1, p_busy8 = 1'b0;
   logic [15:0] cap8 = '0;
   int          cs_start8 = 0, load8 = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy8 && !p_busy8) load8 = cyc;
         if (!cs_n8 && p_cs8) begin
            cs_start8 = cyc;
            cap8      = '0;
         end
         if (sclk8 && !p_sclk8) cap8 = {cap8[14:0], mosi8};
         if (cs_n8 && !p_cs8) begin
            if (exp8.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame8: got %0h expected none", cap8);
            end else begin
               check("frame8", cap8, exp8.pop_front());
               check("cs_low_len8", cyc - cs_start8, 32);
            end
         end
         if (done8 && lat8.size() != 0) check("latency8", cyc - load8 + 1, lat8.pop_front());
         p_sclk8 = sclk8;
         p_cs8   = cs_n8;
         p_busy8 = busy8;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n, input int limit, input string name);
      int seen = 0;
      int k = 0;
      while (seen < n && k < limit) begin
         @(negedge clk);
         k++;
         if (done) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, seen, n);
      end
   endtask

   int r0, l0, c0;

   initial begin
      rst = 1'b1; start = 1'b0; en1 = 1'b0; en2 = 1'b0; d1 = '0; d2 = '0;
      start8 = 1'b0; en1_8 = 1'b0; d1_8 = '0; d2_8 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_ldac_n", ldac_n, 1);
      check("rst_cs_n8", cs_n8, 1);
      rst = 1'b0;
      mon_en = 1'b1;

      // Both channels
      en1 = 1'b1; en2 = 1'b1; d1 = 12'hABC; d2 = 12'h123;
      exp_frames.push_back(16'h1ABC); exp_frames.push_back(16'h3123); exp_lat.push_back(136);
      r0 = rises_total; l0 = ldac_pulses;
      pulse_start();
      wait_done(1, 300, "both");
      repeat (3) @(negedge clk);
      check("both_rises", rises_total - r0, 32);
      check("both_ldac", ldac_pulses - l0, 1);

      // Channel 2 only
      en1 = 1'b0; en2 = 1'b1; d2 = 12'h800;
      exp_frames.push_back(16'h3800); exp_lat.push_back(70);
      c0 = cs_falls;
      pulse_start();
      wait_done(1, 200, "ch2");
      repeat (3) @(negedge clk);
      check("ch2_frames", cs_falls - c0, 1);

      // No channel enabled
      en1 = 1'b0; en2 = 1'b0;
      exp_lat.push_back(2);
      r0 = rises_total; l0 = ldac_pulses; c0 = cs_falls;
      pulse_start();
      wait_done(1, 20, "none");
      repeat (3) @(negedge clk);
      check("none_rises", rises_total - r0, 0);
      check("none_ldac", ldac_pulses - l0, 0);
      check("none_cs", cs_falls - c0, 0);

      // Start held high, data changed mid-frame
      en1 = 1'b1; en2 = 1'b1; d1 = 12'h5A5; d2 = 12'h0F0;
      exp_frames.push_back(16'h15A5); exp_frames.push_back(16'h30F0); exp_lat.push_back(136);
      exp_frames.push_back(16'h1FFF); exp_frames.push_back(16'h3001); exp_lat.push_back(136);
      @(negedge clk);
      start = 1'b1;
      repeat (20) @(negedge clk);
      d1 = 12'hFFF; d2 = 12'h001;
      wait_done(2, 400, "held");
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("held_no_third", busy, 0);

      // Reset at the 5th SCLK rise of frame 1
      en1 = 1'b1; en2 = 1'b1; d1 = 12'h111; d2 = 12'h222;
      abort_exp = 1'b1;
      l0 = ldac_pulses;
      pulse_start();
      begin
         int  r = 0;
         int  k = 0;
         logic ps = 1'b0;
         while (r < 5 && k < 200) begin
            @(negedge clk);
            k++;
            if (sclk && !ps) r++;
            ps = sclk;
         end
         check("abort_reached_5th_rise", r, 5);
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_cs_n", cs_n, 1);
      check("abort_sclk", sclk, 0);
      check("abort_busy", busy, 0);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      check("abort_no_ldac", ldac_pulses - l0, 0);
      en1 = 1'b1; en2 = 1'b0; d1 = 12'h7FF;
      exp_frames.push_back(16'h17FF); exp_lat.push_back(70);
      pulse_start();
      wait_done(1, 200, "after_abort");
      repeat (3) @(negedge clk);

      // 8-bit sample, SCLK_DIV=1
      en1_8 = 1'b1; d1_8 = 8'hFF;
      exp8.push_back(16'h1FF0); lat8.push_back(36);
      @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      begin
         int k = 0;
         while (!done8 && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("done8_seen", done8, 1);
      end
      repeat (5) @(negedge clk);
      check("ldac_n8_idle", ldac_n8, 1);

      check("total_rises", rises_total, 133);
      check("total_ldac", ldac_pulses, 5);
      check("total_cs_falls", cs_falls, 9);
      check("total_dones", dones, 6);
      check("frames_left", exp_frames.size(), 0);
      check("lat_left", exp_lat.size(), 0);
      check("frames8_left", exp8.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
